// File: rtl/ds_pkg.sv
// Shared constants and slot field types for the decode-stage operand slot.
package ds_pkg;
  localparam int RA_WD = 5;
  localparam logic [RA_WD-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             en;
    logic [RA_WD-1:0] addr;
  } src_t;
endpackage

// File: rtl/ds_operand_stage_if.sv
// Upstream decode bus into the operand slot: valid/allowin handshake plus payload and sources.
interface ds_operand_stage_if #(
  parameter int PAYLOAD_WD = 64
);
  import ds_pkg::*;

  logic                  in_valid;
  logic                  in_allowin;
  logic [PAYLOAD_WD-1:0] in_payload;
  logic                  in_src1_en;
  logic                  in_src2_en;
  logic [RA_WD-1:0]      in_src1_addr;
  logic [RA_WD-1:0]      in_src2_addr;

  modport master (
    output in_valid, in_payload, in_src1_en, in_src2_en, in_src1_addr, in_src2_addr,
    input  in_allowin
  );

  modport slave (
    input  in_valid, in_payload, in_src1_en, in_src2_en, in_src1_addr, in_src2_addr,
    output in_allowin
  );
endinterface

// File: rtl/ds_fwd_select.sv
// Priority forwarding matcher for one source operand; the youngest (lowest-index) producer wins.
module ds_fwd_select
  import ds_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int XLEN    = 32
) (
  input  logic                    en,
  input  logic [RA_WD-1:0]        addr,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic [RA_WD*NUM_FWD-1:0] fwd_dest,
  input  logic [XLEN*NUM_FWD-1:0] fwd_result,
  input  logic [XLEN-1:0]         rf_rdata,
  output logic [XLEN-1:0]         value,
  output logic                    blocked
);

  logic            hit;
  logic            hit_rdy;
  logic [XLEN-1:0] hit_val;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_val = rf_rdata;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && en && (addr != REG_ZERO) &&
          (fwd_dest[RA_WD*i +: RA_WD] == addr)) begin
        hit     = 1'b1;
        hit_rdy = fwd_ready[i];
        hit_val = fwd_result[XLEN*i +: XLEN];
      end
    end
  end

  assign value   = (hit && hit_rdy) ? hit_val : rf_rdata;
  assign blocked = hit && !hit_rdy;

endmodule

// File: rtl/ds_operand_stage.sv
// Decode-stage slot: holds one instruction, reads/forwards two operands, stalls on unready producers.
module ds_operand_stage
  import ds_pkg::*;
#(
  parameter int NUM_FWD    = 3,
  parameter int XLEN       = 32,
  parameter int PAYLOAD_WD = 64,
  parameter int CNT_WD     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  ds_operand_stage_if.slave        up,
  output logic [RA_WD-1:0]         rf_raddr1,
  output logic [RA_WD-1:0]         rf_raddr2,
  input  logic [XLEN-1:0]          rf_rdata1,
  input  logic [XLEN-1:0]          rf_rdata2,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD-1:0]       fwd_ready,
  input  logic [RA_WD*NUM_FWD-1:0] fwd_dest,
  input  logic [XLEN*NUM_FWD-1:0]  fwd_result,
  output logic                     out_valid,
  input  logic                     out_allowin,
  output logic [PAYLOAD_WD-1:0]    out_payload,
  output logic [XLEN-1:0]          out_src1,
  output logic [XLEN-1:0]          out_src2,
  output logic [CNT_WD-1:0]        stall_cnt
);

  function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] c);
    return (&c) ? c : c + CNT_WD'(1);
  endfunction

  logic                  vld_p1_d, vld_p1_q;
  logic [PAYLOAD_WD-1:0] payload_p1_d, payload_p1_q;
  src_t                  src1_p1_d, src1_p1_q;
  src_t                  src2_p1_d, src2_p1_q;
  logic [CNT_WD-1:0]     stall_cnt_d, stall_cnt_q;

  logic blk1, blk2, stall, ready_go, accept;

  ds_fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_sel1 (
    .en(src1_p1_q.en), .addr(src1_p1_q.addr),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest),
    .fwd_result(fwd_result), .rf_rdata(rf_rdata1),
    .value(out_src1), .blocked(blk1)
  );

  ds_fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_sel2 (
    .en(src2_p1_q.en), .addr(src2_p1_q.addr),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest),
    .fwd_result(fwd_result), .rf_rdata(rf_rdata2),
    .value(out_src2), .blocked(blk2)
  );

  assign stall         = vld_p1_q && (blk1 || blk2);
  assign ready_go      = vld_p1_q && !stall;
  assign out_valid     = ready_go && !flush;
  assign up.in_allowin = !vld_p1_q || (ready_go && out_allowin);
  assign accept        = up.in_valid && up.in_allowin && !flush;

  // p0 -> p1: slot capture on acceptance; operands are re-resolved every cycle, never latched
  always_comb begin
    vld_p1_d     = vld_p1_q;
    payload_p1_d = payload_p1_q;
    src1_p1_d    = src1_p1_q;
    src2_p1_d    = src2_p1_q;
    stall_cnt_d  = stall_cnt_q;
    if (flush) begin
      vld_p1_d = 1'b0;
    end else if (up.in_allowin) begin
      vld_p1_d = up.in_valid;
    end
    if (accept) begin
      payload_p1_d = up.in_payload;
      src1_p1_d    = '{en: up.in_src1_en, addr: up.in_src1_addr};
      src2_p1_d    = '{en: up.in_src2_en, addr: up.in_src2_addr};
    end
    if (stall && !flush) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q     <= 1'b0;
      payload_p1_q <= '0;
      src1_p1_q    <= '0;
      src2_p1_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      payload_p1_q <= payload_p1_d;
      src1_p1_q    <= src1_p1_d;
      src2_p1_q    <= src2_p1_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_payload = payload_p1_q;
  assign rf_raddr1   = src1_p1_q.addr;
  assign rf_raddr2   = src2_p1_q.addr;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_ds_operand_stage.sv
// Scoreboard bench for ds_operand_stage: directed issue vectors, monitor pops on each downstream handshake.
module tb_ds_operand_stage;
  import ds_pkg::*;

  typedef struct packed {
    logic [63:0] pl;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  exp_t sb[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default configuration
  logic        reset, flush, out_allowin, out_valid;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2, out_src1, out_src2;
  logic [2:0]  fwd_valid, fwd_ready;
  logic [14:0] fwd_dest;
  logic [95:0] fwd_result;
  logic [63:0] out_payload;
  logic [15:0] stall_cnt;
  ds_operand_stage_if #(.PAYLOAD_WD(64)) ifa ();

  ds_operand_stage #(.NUM_FWD(3), .XLEN(32), .PAYLOAD_WD(64), .CNT_WD(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .up(ifa),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_result(fwd_result),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
    .out_src1(out_src1), .out_src2(out_src2), .stall_cnt(stall_cnt)
  );

  // DUT B: narrow counter for saturation
  logic        b_reset, b_out_valid;
  logic [4:0]  b_raddr1, b_raddr2, b_fwd_dest;
  logic [31:0] b_src1, b_src2, b_fwd_result;
  logic [0:0]  b_fwd_valid, b_fwd_ready;
  logic [63:0] b_out_payload;
  logic [3:0]  b_stall_cnt;
  ds_operand_stage_if #(.PAYLOAD_WD(64)) ifb ();

  ds_operand_stage #(.NUM_FWD(1), .XLEN(32), .PAYLOAD_WD(64), .CNT_WD(4)) dut_b (
    .clk(clk), .reset(b_reset), .flush(1'b0), .up(ifb),
    .rf_raddr1(b_raddr1), .rf_raddr2(b_raddr2),
    .rf_rdata1(32'h0), .rf_rdata2(32'h0),
    .fwd_valid(b_fwd_valid), .fwd_ready(b_fwd_ready), .fwd_dest(b_fwd_dest), .fwd_result(b_fwd_result),
    .out_valid(b_out_valid), .out_allowin(1'b1), .out_payload(b_out_payload),
    .out_src1(b_src1), .out_src2(b_src2), .stall_cnt(b_stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] pl, input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    ifa.in_valid     = 1'b1;
    ifa.in_payload   = pl;
    ifa.in_src1_en   = e1;
    ifa.in_src1_addr = a1;
    ifa.in_src2_en   = e2;
    ifa.in_src2_addr = a2;
  endtask

  // Monitor: every downstream handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && out_valid && out_allowin) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got payload %0h expected no output", out_payload);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        if (out_payload !== e.pl || out_src1 !== e.s1 || out_src2 !== e.s2) begin
          errors++;
          $display("FAIL sb_out: got %0h/%0h/%0h expected %0h/%0h/%0h",
                   out_payload, out_src1, out_src2, e.pl, e.s1, e.s2);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_allowin = 1'b1;
    rf_rdata1 = '0; rf_rdata2 = '0;
    fwd_valid = '0; fwd_ready = '0; fwd_dest = '0; fwd_result = '0;
    ifa.in_valid = 1'b0; ifa.in_payload = '0;
    ifa.in_src1_en = 1'b0; ifa.in_src1_addr = '0; ifa.in_src2_en = 1'b0; ifa.in_src2_addr = '0;
    b_reset = 1'b1; b_fwd_valid = '0; b_fwd_ready = '0; b_fwd_dest = '0; b_fwd_result = '0;
    ifb.in_valid = 1'b0; ifb.in_payload = '0;
    ifb.in_src1_en = 1'b0; ifb.in_src1_addr = '0; ifb.in_src2_en = 1'b0; ifb.in_src2_addr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_allowin", {63'd0, ifa.in_allowin}, 64'd1);
    chk("rst_payload", out_payload, 64'd0);
    chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("rst_raddr1", {59'd0, rf_raddr1}, 64'd0);
    chk("rst_raddr2", {59'd0, rf_raddr2}, 64'd0);

    // Plain register-file read
    tick();
    reset = 1'b0; rf_rdata1 = 32'h1234; rf_rdata2 = 32'h9999;
    issue(64'hA1, 1'b1, 5'd5, 1'b0, 5'd0);
    sb.push_back('{pl: 64'hA1, s1: 32'h1234, s2: 32'h9999});
    @(negedge clk);
    chk("t1_not_yet", {63'd0, out_valid}, 64'd0);
    tick();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_src1", {32'd0, out_src1}, 64'h1234);
    chk("t1_raddr1", {59'd0, rf_raddr1}, 64'd5);
    chk("t1_stall_cnt", {48'd0, stall_cnt}, 64'd0);

    // Youngest producer wins, then back-to-back issue
    tick();
    rf_rdata1 = 32'h4444; rf_rdata2 = 32'h2222;
    fwd_valid = 3'b101; fwd_ready = 3'b101;
    fwd_dest = {5'd7, 5'd9, 5'd7};
    fwd_result = {32'hCCCC, 32'h1111, 32'hAAAA};
    issue(64'hA2, 1'b1, 5'd4, 1'b1, 5'd7);
    sb.push_back('{pl: 64'hA2, s1: 32'h4444, s2: 32'hAAAA});
    tick();
    issue(64'hA3, 1'b1, 5'd2, 1'b0, 5'd0);
    sb.push_back('{pl: 64'hA3, s1: 32'h4444, s2: 32'h2222});
    @(negedge clk);
    chk("t2_src2_youngest", {32'd0, out_src2}, 64'hAAAA);
    tick();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("t2_b2b_valid", {63'd0, out_valid}, 64'd1);
    tick();
    fwd_valid = '0; fwd_ready = '0;
    @(negedge clk);
    chk("t2_drained", {63'd0, out_valid}, 64'd0);

    // Load-use stall for two cycles
    fwd_valid = 3'b001; fwd_ready = 3'b000;
    fwd_dest = {5'd0, 5'd0, 5'd3}; fwd_result = {64'd0, 32'h55};
    tick();
    issue(64'hA4, 1'b1, 5'd3, 1'b0, 5'd0);
    sb.push_back('{pl: 64'hA4, s1: 32'h55, s2: 32'h2222});
    tick();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_stall1_valid", {63'd0, out_valid}, 64'd0);
    chk("t3_stall1_allowin", {63'd0, ifa.in_allowin}, 64'd0);
    tick();
    @(negedge clk);
    chk("t3_stall2_valid", {63'd0, out_valid}, 64'd0);
    tick();
    fwd_ready = 3'b001;
    @(negedge clk);
    chk("t3_release_valid", {63'd0, out_valid}, 64'd1);
    chk("t3_src1", {32'd0, out_src1}, 64'h55);
    chk("t3_stall_cnt", {48'd0, stall_cnt}, 64'd2);

    // r0 never matches or blocks
    tick();
    fwd_valid = 3'b001; fwd_ready = 3'b000; fwd_dest = 15'd0;
    issue(64'hA5, 1'b1, 5'd0, 1'b1, 5'd0);
    sb.push_back('{pl: 64'hA5, s1: 32'h4444, s2: 32'h2222});
    tick();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_r0_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_r0_src1", {32'd0, out_src1}, 64'h4444);
    chk("t4_stall_cnt", {48'd0, stall_cnt}, 64'd2);

    // Flush while stalled, with a new instruction offered
    tick();
    fwd_dest = {5'd0, 5'd0, 5'd3};
    issue(64'hA6, 1'b1, 5'd3, 1'b0, 5'd0);
    tick();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_stalled", {63'd0, out_valid}, 64'd0);
    tick();
    flush = 1'b1;
    issue(64'hA7, 1'b1, 5'd1, 1'b0, 5'd0);
    @(negedge clk);
    chk("t5_flush_valid", {63'd0, out_valid}, 64'd0);
    tick();
    flush = 1'b0; ifa.in_valid = 1'b0; fwd_valid = '0;
    @(negedge clk);
    chk("t5_after_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_after_allowin", {63'd0, ifa.in_allowin}, 64'd1);
    chk("t5_after_cnt", {48'd0, stall_cnt}, 64'd3);
    chk("t5_after_payload", out_payload, 64'hA6);

    // Flush into an empty slot must not capture the input
    tick();
    flush = 1'b1;
    issue(64'hA8, 1'b1, 5'd1, 1'b0, 5'd0);
    tick();
    flush = 1'b0; ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_empty_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_empty_payload", out_payload, 64'hA6);

    // Flush suppresses an otherwise-ready output
    tick();
    issue(64'hA9, 1'b1, 5'd1, 1'b0, 5'd0);
    tick();
    ifa.in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("t7_flush_ready", {63'd0, out_valid}, 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t7_flushed", {63'd0, out_valid}, 64'd0);

    // Downstream backpressure holds the slot
    tick();
    issue(64'hAA, 1'b1, 5'd6, 1'b0, 5'd0);
    sb.push_back('{pl: 64'hAA, s1: 32'h4444, s2: 32'h2222});
    out_allowin = 1'b0;
    tick();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("t8_bp_valid", {63'd0, out_valid}, 64'd1);
    chk("t8_bp_allowin", {63'd0, ifa.in_allowin}, 64'd0);
    tick();
    out_allowin = 1'b1;
    @(negedge clk);
    chk("t8_bp_cnt", {48'd0, stall_cnt}, 64'd3);

    // Reset in the middle of a stall
    tick();
    fwd_valid = 3'b001; fwd_ready = 3'b000;
    issue(64'hAB, 1'b1, 5'd3, 1'b0, 5'd0);
    tick();
    ifa.in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t9_cnt_before", {48'd0, stall_cnt}, 64'd4);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; fwd_valid = '0;
    @(negedge clk);
    chk("t9_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t9_rst_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("t9_rst_allowin", {63'd0, ifa.in_allowin}, 64'd1);

    // Saturation on the 4-bit counter instance
    tick();
    b_reset = 1'b0;
    b_fwd_valid = 1'b1; b_fwd_ready = 1'b0; b_fwd_dest = 5'd3; b_fwd_result = 32'h77;
    ifb.in_valid = 1'b1; ifb.in_payload = 64'hB1;
    ifb.in_src1_en = 1'b1; ifb.in_src1_addr = 5'd3;
    tick();
    ifb.in_valid = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("t10_sat_cnt", {60'd0, b_stall_cnt}, 64'hF);
    chk("t10_sat_valid", {63'd0, b_out_valid}, 64'd0);

    tick();
    chk("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);
    chk("sb_pops", {32'd0, 32'(pops)}, 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
